wbdbgbus_cmd_fifo: RTL and testbench
====================================

// Module: wbdbgbus_cmd_fifo
// PURPOSE
//  Synchronous first-word-fall-through FIFO between the UART packet receiver and wbdbgbusmaster.
//  Buffers 36-bit debug-bus command words so bursts arriving while the master is busy are not lost.
//  Reports occupancy and a sticky overflow flag, and flushes on bus reset.
//  The same block instantiated with WIDTH=36 also serves as the response queue toward the UART serializer.
// PARAMETERS
//  WIDTH   36  data word width in bits ({4-bit opcode, 32-bit payload}); >= 1
//  DEPTH   16  number of entries; power of two, >= 2; anything else is a compile-time $error
// PORTS
//  i_clk       in   1             single clock; all logic on posedge
//  i_rst_n     in   1             asynchronous active-low reset
//  i_flush     in   1             synchronous flush (driven by cmd_reset); empties FIFO, clears overflow
//  i_wr_valid  in   1             write request; single-cycle pulses allowed
//  o_wr_ready  out  1             FIFO can accept a word this cycle (== !o_full)
//  i_wr_data   in   WIDTH         write word
//  o_rd_valid  out  1             o_rd_data holds the head word (== !o_empty)
//  i_rd_ready  in   1             consumer takes the head word when o_rd_valid is high
//  o_rd_data   out  WIDTH         head word; FWFT, so valid without a prior read strobe
//  o_count     out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
//  o_full      out  1             o_count == DEPTH
//  o_empty     out  1             o_count == 0
//  o_overflow  out  1             sticky: a write was presented while full
// BEHAVIOUR
//  Reset (i_rst_n low, asynchronous): wr_ptr=rd_ptr=0, count=0, o_overflow=0, o_empty=1, o_full=0,
//   o_wr_ready=1, o_rd_valid=0. o_rd_data is don't-care while empty; the storage array has no reset.
//  Pointers: wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap naturally (DEPTH-1 -> 0). count is a separate
//   register of $clog2(DEPTH)+1 bits; full/empty derive from count, never from pointer compare.
//  Write accepted (wr_fire) = i_wr_valid & !o_full & !i_flush: mem[wr_ptr]<=i_wr_data, wr_ptr++.
//  Read accepted (rd_fire) = i_rd_ready & !o_empty & !i_flush: rd_ptr++.
//  count next: +1 on wr_fire only, -1 on rd_fire only, unchanged when both or neither fire.
//  o_wr_ready depends only on registered state (no combinational path from i_rd_ready); when full, a
//   write in the same cycle as a read is refused and sets o_overflow.
//  Latency: word written in cycle N appears on o_rd_data with o_rd_valid=1 in cycle N+1. No empty-bypass.
//  o_rd_data = mem[rd_ptr] (combinational read from registers); it advances the cycle after rd_fire.
//  Overflow: i_wr_valid & o_full & !i_flush sets o_overflow; stays set until i_flush or reset. The word is
//   dropped; FIFO contents and pointers are unchanged.
//  Flush: i_flush has priority over any same-cycle write or read. Next cycle: ptrs=0, count=0, empty=1,
//   overflow=0. A flush while full or mid-burst discards all entries; no partial word survives.
//  Read while empty and write while full are ignored (no pointer motion, no underflow).
//  Ordering: strict FIFO; every accepted word is read exactly once, in order, unless flushed.
// STRUCTURE
//  wbdbgbus_pkg: CMD_WIDTH=36, opcode constants (incl. RESET=4'b1111, INT_1..INT_4=4'b1000..4'b1011),
//   default DEPTH. This FIFO itself is opcode-agnostic and imports only CMD_WIDTH.
//  Single module, no sub-module: register array + two pointers + count + overflow flag. A separate RAM
//   sub-module is not justified at DEPTH<=64.
//  Top-level integration: receiver -> wbdbgbus_cmd_fifo -> wbdbgbusmaster (i_rd_ready = cmd_ready);
//   i_flush = cmd_reset.
// TESTING
//  T1 fill/drain: write 16 words 0x0_0000_0001..0x0_0000_0010 back-to-back, DEPTH=16 -> o_full=1,
//   o_count=16; drain with i_rd_ready=1 -> same 16 words in order, then o_empty=1, o_count=0.
//  T2 overflow: on the full FIFO, pulse i_wr_valid with 0xF_DEAD_BEEF -> o_overflow=1, o_count stays 16,
//   drained data has no 0xFDEADBEEF; o_overflow still 1 after drain.
//  T3 simultaneous: at count=5, drive wr_fire and rd_fire together for 20 cycles -> count stays 5,
//   output order is preserved across the pointer wrap at 15->0.
//  T4 flush: count=9, o_overflow=1, assert i_flush together with i_wr_valid and i_rd_ready -> next cycle
//   count=0, o_empty=1, o_overflow=0; no read consumed and the concurrent write is dropped.
//  T5 async reset mid-operation: drop i_rst_n between clock edges with count=7 -> outputs take reset
//   values immediately without waiting for a clock edge; after release, first write 0x2_0000_00AA is
//   read back at N+1.
//  T6 random: 10k cycles of random valid/ready against a scoreboard queue -> no mismatch, no loss;
//   o_count always equals the model occupancy.

Source files
------------

// File: rtl/wbdbgbus_pkg.sv
// Shared debug-bus definitions: command word width, opcodes and default queue depth.
package wbdbgbus_pkg;

    localparam int unsigned CMD_WIDTH     = 36;
    localparam int unsigned OPCODE_WIDTH  = 4;
    localparam int unsigned PAYLOAD_WIDTH = CMD_WIDTH - OPCODE_WIDTH;
    localparam int unsigned CMD_DEPTH     = 16;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_INT_1 = 4'b1000,
        OP_INT_2 = 4'b1001,
        OP_INT_3 = 4'b1010,
        OP_INT_4 = 4'b1011,
        OP_RESET = 4'b1111
    } opcode_e;

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0]  opcode;
        logic [PAYLOAD_WIDTH-1:0] payload;
    } cmd_word_t;

endpackage

// File: rtl/wbdbgbus_cmd_fifo.sv
// First-word-fall-through command/response queue with occupancy, sticky overflow and flush.
module wbdbgbus_cmd_fifo
    import wbdbgbus_pkg::CMD_WIDTH;
#(
    parameter int unsigned WIDTH = CMD_WIDTH,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_flush,
    input  logic                       i_wr_valid,
    output logic                       o_wr_ready,
    input  logic [WIDTH-1:0]           i_wr_data,
    output logic                       o_rd_valid,
    input  logic                       i_rd_ready,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("wbdbgbus_cmd_fifo: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;

    logic w_full;
    logic w_empty;
    logic w_wr_fire;
    logic w_rd_fire;

    // Full/empty come from the count register only, so o_wr_ready never sees i_rd_ready.
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == CW'(0));
    assign w_wr_fire = i_wr_valid & ~w_full  & ~i_flush;
    assign w_rd_fire = i_rd_ready & ~w_empty & ~i_flush;

    // Storage carries no reset; contents are only meaningful below the count.
    always_ff @(posedge i_clk) begin
        if (w_wr_fire) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= AW'(0);
            r_rd_ptr   <= AW'(0);
            r_count    <= CW'(0);
            r_overflow <= 1'b0;
        end else if (i_flush) begin
            r_wr_ptr   <= AW'(0);
            r_rd_ptr   <= AW'(0);
            r_count    <= CW'(0);
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_fire) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr_fire, w_rd_fire})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (i_wr_valid && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_wr_ready = ~w_full;
    assign o_rd_valid = ~w_empty;
    assign o_rd_data  = r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_wbdbgbus_cmd_fifo.sv
// Directed-vector and scoreboard bench for the debug-bus command FIFO (WIDTH=36, DEPTH=16).
module tb_wbdbgbus_cmd_fifo;

    localparam int unsigned W = 36;
    localparam int unsigned D = 16;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          wr_valid;
    logic          wr_ready;
    logic [W-1:0]  wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [W-1:0]  rd_data;
    logic [4:0]    count;
    logic          full;
    logic          empty;
    logic          overflow;

    int n_chk;
    int n_fail;

    wbdbgbus_cmd_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_flush    (flush),
        .i_wr_valid (wr_valid),
        .o_wr_ready (wr_ready),
        .i_wr_data  (wr_data),
        .o_rd_valid (rd_valid),
        .i_rd_ready (rd_ready),
        .o_rd_data  (rd_data),
        .o_count    (count),
        .o_full     (full),
        .o_empty    (empty),
        .o_overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        f;
        logic        wv;
        logic [35:0] wd;
        logic        rr;
        int          e_count;
        logic        e_ovf;
        logic [35:0] e_head;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic f, input logic wv, input logic [35:0] d, input logic rr);
        flush    = f;
        wr_valid = wv;
        wr_data  = d;
        rd_ready = rr;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Check the flags implied by an expected occupancy.
    task automatic chk_state(input string name, input int c, input logic ovf);
        chk({name, ".count"},    64'(count),    64'(c));
        chk({name, ".empty"},    64'(empty),    64'(c == 0));
        chk({name, ".full"},     64'(full),     64'(c == D));
        chk({name, ".rd_valid"}, 64'(rd_valid), 64'(c != 0));
        chk({name, ".wr_ready"}, 64'(wr_ready), 64'(c != D));
        chk({name, ".overflow"}, 64'(overflow), 64'(ovf));
    endtask

    vec_t vecs[9];
    logic [35:0] q[$];
    logic        m_ovf;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0);

        vecs[0] = '{1'b0, 1'b1, 36'h1_0000_0011, 1'b0, 1, 1'b0, 36'h1_0000_0011};
        vecs[1] = '{1'b0, 1'b1, 36'h1_0000_0022, 1'b0, 2, 1'b0, 36'h1_0000_0011};
        vecs[2] = '{1'b0, 1'b1, 36'h1_0000_0033, 1'b1, 2, 1'b0, 36'h1_0000_0022};
        vecs[3] = '{1'b0, 1'b0, 36'h0,           1'b1, 1, 1'b0, 36'h1_0000_0033};
        vecs[4] = '{1'b0, 1'b0, 36'h0,           1'b1, 0, 1'b0, 36'h0};
        vecs[5] = '{1'b0, 1'b0, 36'h0,           1'b1, 0, 1'b0, 36'h0};
        vecs[6] = '{1'b1, 1'b1, 36'h1_0000_0044, 1'b0, 0, 1'b0, 36'h0};
        vecs[7] = '{1'b0, 1'b1, 36'h1_0000_0055, 1'b0, 1, 1'b0, 36'h1_0000_0055};
        vecs[8] = '{1'b1, 1'b0, 36'h0,           1'b1, 0, 1'b0, 36'h0};

        // Reset values while held in reset.
        #12;
        chk_state("reset", 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Table-driven vectors.
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].f, vecs[i].wv, vecs[i].wd, vecs[i].rr);
            cyc();
            chk_state($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_ovf);
            if (vecs[i].e_count != 0)
                chk($sformatf("vec%0d.head", i), 64'(rd_data), 64'(vecs[i].e_head));
        end
        drive(1'b0, 1'b0, '0, 1'b0);

        // T1 fill.
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, 1'b1, 36'(i), 1'b0);
            cyc();
        end
        drive(1'b0, 1'b0, '0, 1'b0);
        chk_state("t1_full", 16, 1'b0);

        // T2 overflow pulse on a full FIFO.
        drive(1'b0, 1'b1, 36'hF_DEAD_BEEF, 1'b0);
        cyc();
        drive(1'b0, 1'b0, '0, 1'b0);
        chk_state("t2_ovf", 16, 1'b1);

        // T1/T2 drain in order.
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("t1_drain%0d", i), 64'(rd_data), 64'(i));
            drive(1'b0, 1'b0, '0, 1'b1);
            cyc();
        end
        drive(1'b0, 1'b0, '0, 1'b0);
        chk_state("t1_empty", 0, 1'b1);

        // T3 simultaneous read/write at count 5 across pointer wrap.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 36'(100 + i), 1'b0);
            cyc();
        end
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("t3_head%0d", k), 64'(rd_data), 64'(100 + k));
            drive(1'b0, 1'b1, 36'(105 + k), 1'b1);
            cyc();
            chk($sformatf("t3_count%0d", k), 64'(count), 64'd5);
        end
        drive(1'b0, 1'b0, '0, 1'b0);
        chk("t3_head_end", 64'(rd_data), 64'd120);

        // T4 flush wins over concurrent write and read.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 36'(200 + i), 1'b0);
            cyc();
        end
        chk_state("t4_pre", 9, 1'b1);
        drive(1'b1, 1'b1, 36'h3_0000_0001, 1'b1);
        cyc();
        drive(1'b0, 1'b0, '0, 1'b0);
        chk_state("t4_post", 0, 1'b0);
        cyc();
        chk_state("t4_hold", 0, 1'b0);

        // T5 asynchronous reset between edges.
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b1, 36'(300 + i), 1'b0);
            cyc();
        end
        drive(1'b0, 1'b0, '0, 1'b0);
        chk_state("t5_pre", 7, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("t5_async", 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        drive(1'b0, 1'b1, 36'h2_0000_00AA, 1'b0);
        cyc();
        drive(1'b0, 1'b0, '0, 1'b0);
        chk_state("t5_after", 1, 1'b0);
        chk("t5_data", 64'(rd_data), 64'h2_0000_00AA);
        drive(1'b0, 1'b0, '0, 1'b1);
        cyc();
        drive(1'b0, 1'b0, '0, 1'b0);
        chk_state("t5_drained", 0, 1'b0);

        // T6 random traffic against a queue model.
        q.delete();
        m_ovf = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            logic f, wv, rr, wf, rf;
            logic [35:0] d;
            f  = ($urandom_range(0, 299) == 0);
            wv = ($urandom_range(0, 99) < 55);
            rr = ($urandom_range(0, 99) < 45);
            d  = {4'($urandom_range(0, 15)), 32'($urandom)};
            drive(f, wv, d, rr);
            wf = wv && (q.size() < D) && !f;
            rf = rr && (q.size() > 0) && !f;
            cyc();
            if (f) begin
                q.delete();
                m_ovf = 1'b0;
            end else begin
                if (wv && q.size() == D) m_ovf = 1'b1;
                if (rf) void'(q.pop_front());
                if (wf) q.push_back(d);
            end
            chk("t6_count", 64'(count), 64'(q.size()));
            chk("t6_overflow", 64'(overflow), 64'(m_ovf));
            if (q.size() > 0)
                chk("t6_head", 64'(rd_data), 64'(q[0]));
        end
        drive(1'b0, 1'b0, '0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
